xbus_arbiter: RTL

Two-master arbiter for the shared peripheral bus that feeds the address decoder (memory, register file, LED, switch, button, ALU, display and complement peripherals).
- Master 0 is the processor; master 1 is the display/button scan engine.
- Each master issues a request/ack transaction.
- The arbiter grants round-robin, drives one decoder access cycle, captures read data and trap status, and returns an ack.
- Placed between the masters and the decoder's addr/sel inputs and its data_to_rd/trap_sel outputs.

---
 rtl/xbus_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/xbus_arbiter.sv
// xbus_arbiter: round-robin two-master arbiter driving one decoder access per transaction
module xbus_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 32,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic                m0_we,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic                m0_ack,
    output logic                m0_err,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_req,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic                m1_we,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic                m1_ack,
    output logic                m1_err,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic                bus_sel,
    output logic                bus_we,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_trap,
    output logic [ERRCNT_W-1:0] trap_cnt
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state_q, state_d;
    logic last_q, last_d, gnt_q, gnt_d, win;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0][DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0] err_q, err_d;
    logic [ERRCNT_W-1:0] cnt_q, cnt_d;
    // on contention the master that did not win last time goes next
    assign win = (m0_req & m1_req) ? ~last_q : m1_req;
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (m0_req | m1_req) begin
                state_d = ACCESS;
                gnt_d   = win;
                last_d  = win;
                addr_d  = win ? m1_addr : m0_addr;
                we_d    = win ? m1_we : m0_we;
                wdata_d = win ? m1_wdata : m0_wdata;
            end
            ACCESS: begin
                state_d        = RESP;
                rdata_d[gnt_q] = bus_trap ? '0 : bus_rdata;
                err_d[gnt_q]   = bus_trap;
                cnt_d          = (bus_trap && !(&cnt_q)) ? cnt_q + ERRCNT_W'(1) : cnt_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
    assign bus_sel   = state_q == ACCESS;
    assign bus_addr  = addr_q;
    assign bus_we    = we_q;
    assign bus_wdata = wdata_q;
    assign m0_ack    = (state_q == RESP) & ~gnt_q;
    assign m1_ack    = (state_q == RESP) & gnt_q;
    assign m0_rdata  = rdata_q[0];
    assign m1_rdata  = rdata_q[1];
    assign m0_err    = err_q[0];
    assign m1_err    = err_q[1];
    assign trap_cnt  = cnt_q;
endmodule
